// File: rtl/grid_pkg.sv
// Shared grid geometry for the colour controller and the VGA renderer.
// Cells are numbered column-major descending: top-left is 15.
package grid_pkg;

    localparam int GRID_N  = 4;
    localparam int CELL_AW = 4;
    localparam int COLOR_W = 3;
    localparam int N_CELLS = GRID_N * GRID_N;

    localparam int N_BTN     = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_COLOR = 4;

    // Column c (left->right), row r (top->bottom) -> 15 - 4*c - r.
    function automatic logic [CELL_AW-1:0] rc_to_idx(input logic [1:0] r, input logic [1:0] c);
        return 4'd15 - {c, 2'b00} - {2'b00, r};
    endfunction

endpackage

// File: rtl/grid_color_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-counter debouncer and rising-edge pulse.
// A button already held when reset is released stays silent until it has been seen low.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [1:0]    fill_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          armed_q;
    logic          armed_d;
    logic          pulse_q;
    logic          pulse_d;

    // Debounce decision: count consecutive disagreeing samples, accept the level on the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        // fill_q[1] marks that sync2_q now holds a real sample rather than its reset value
        if (fill_q[1] && !sync2_q) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        if (sync2_q == state_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            state_d = sync2_q;
            cnt_d   = {CW{1'b0}};
            pulse_d = sync2_q & armed_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, debounce state and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            state_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign level      = state_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/grid_color_ctrl.sv
// 4x4 cell colour register file with button-driven cursor, colour stepping and a blinking
// cursor highlight; the renderer reads it combinationally through posicion -> dirColor.
module grid_color_ctrl
    import grid_pkg::*;
#(
    parameter int                 DEB_CYCLES   = 500000,
    parameter int                 BLINK_CYCLES = 12500000,
    parameter logic [COLOR_W-1:0] INIT_COLOR   = 3'd0,
    parameter logic [COLOR_W-1:0] CURSOR_COLOR = 3'd7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_color,
    input  logic [CELL_AW-1:0] posicion,
    output logic [COLOR_W-1:0] dirColor,
    output logic [CELL_AW-1:0] cursor_idx,
    output logic               blink_phase
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [N_BTN-1:0]   btn_raw_s;
    logic [N_BTN-1:0]   pulse_s;
    logic [N_BTN-1:0]   btn_level_unused_s;

    logic [1:0]         cur_r_q;
    logic [1:0]         cur_r_d;
    logic [1:0]         cur_c_q;
    logic [1:0]         cur_c_d;
    logic [CELL_AW-1:0] cursor_idx_q;

    logic [COLOR_W-1:0] cell_q [N_CELLS];
    logic [COLOR_W-1:0] cell_d [N_CELLS];

    logic [BW-1:0]      blink_cnt_q;
    logic [BW-1:0]      blink_cnt_d;
    logic               blink_q;
    logic               blink_d;
    logic               edit_evt_s;

    assign btn_raw_s = {btn_color, btn_right, btn_left, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk        (clk),
                .rst        (rst),
                .btn_raw    (btn_raw_s[gi]),
                .level      (btn_level_unused_s[gi]),
                .rise_pulse (pulse_s[gi])
            );
        end
    endgenerate

    // Cursor next state: opposing pulses cancel, orthogonal pulses both apply, all mod 4.
    always_comb begin
        if (pulse_s[BTN_UP] && !pulse_s[BTN_DOWN]) begin
            cur_r_d = cur_r_q - 2'd1;
        end else if (pulse_s[BTN_DOWN] && !pulse_s[BTN_UP]) begin
            cur_r_d = cur_r_q + 2'd1;
        end else begin
            cur_r_d = cur_r_q;
        end
        if (pulse_s[BTN_LEFT] && !pulse_s[BTN_RIGHT]) begin
            cur_c_d = cur_c_q - 2'd1;
        end else if (pulse_s[BTN_RIGHT] && !pulse_s[BTN_LEFT]) begin
            cur_c_d = cur_c_q + 2'd1;
        end else begin
            cur_c_d = cur_c_q;
        end
    end

    // Colour step addresses the cursor as it was before any same-cycle move.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            cell_d[i] = cell_q[i];
        end
        if (pulse_s[BTN_COLOR]) begin
            cell_d[cursor_idx_q] = cell_q[cursor_idx_q] + COLOR_W'(1);
        end else begin
            cell_d[cursor_idx_q] = cell_q[cursor_idx_q];
        end
    end

    assign edit_evt_s = |pulse_s;

    // Blink timer: any edit restarts the half-period with the highlight on.
    always_comb begin
        if (edit_evt_s) begin
            blink_cnt_d = {BW{1'b0}};
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = {BW{1'b0}};
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_d     = blink_q;
        end
    end

    // Cursor, register file and blink state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r_q      <= 2'd0;
            cur_c_q      <= 2'd0;
            cursor_idx_q <= 4'd15;
            for (int i = 0; i < N_CELLS; i++) begin
                cell_q[i] <= INIT_COLOR;
            end
            blink_cnt_q  <= {BW{1'b0}};
            blink_q      <= 1'b0;
        end else begin
            cur_r_q      <= cur_r_d;
            cur_c_q      <= cur_c_d;
            cursor_idx_q <= rc_to_idx(cur_r_d, cur_c_d);
            for (int i = 0; i < N_CELLS; i++) begin
                cell_q[i] <= cell_d[i];
            end
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
        end
    end

    // Renderer read port; stays purely combinational so the pixel pipeline sees it in one period.
    always_comb begin
        if ((posicion == cursor_idx_q) && blink_q) begin
            dirColor = CURSOR_COLOR;
        end else begin
            dirColor = cell_q[posicion];
        end
    end

    assign cursor_idx  = cursor_idx_q;
    assign blink_phase = blink_q;

endmodule

// File: tb/tb_grid_color_ctrl.sv
// Randomised and directed bench for grid_color_ctrl against a cycle-level behavioural model.
module tb_grid_color_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0;
    logic [3:0] posicion = 4'd0;
    logic [2:0] dirColor;
    logic [3:0] cursor_idx;
    logic       blink_phase;

    int n_checks = 0;
    int n_errors = 0;

    grid_color_ctrl #(
        .DEB_CYCLES   (DEB),
        .BLINK_CYCLES (BLINK),
        .INIT_COLOR   (3'd0),
        .CURSOR_COLOR (3'd7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_color   (btn_color),
        .posicion    (posicion),
        .dirColor    (dirColor),
        .cursor_idx  (cursor_idx),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state visible during the current clock cycle.
    bit m_valid = 1'b0;
    bit m_s1[5], m_s2[5], m_state[5], m_armed[5], m_pulse[5];
    int m_run[5];
    int m_n;
    int m_cell[16];
    int m_r, m_c;
    int m_k;
    bit m_base;

    function automatic int m_idx();
        return 15 - 4 * m_c - m_r;
    endfunction

    function automatic bit m_phase();
        return m_base ^ bit'((m_k / BLINK) % 2);
    endfunction

    // Per-cycle compare, then advance the model across the coming rising edge.
    initial begin
        bit raw[5];
        bit nxt_pulse[5];
        int vert, horz, e_col;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_col = ((int'(posicion) == m_idx()) && m_phase()) ? 7 : m_cell[posicion];
                check("cursor_idx", cursor_idx, m_idx());
                check("blink_phase", blink_phase, m_phase());
                check("dirColor", dirColor, e_col);
            end
            raw = '{btn_up, btn_down, btn_left, btn_right, btn_color};
            if (rst) begin
                m_valid = 1'b1;
                for (int b = 0; b < 5; b++) begin
                    m_s1[b] = 0; m_s2[b] = 0; m_state[b] = 0; m_armed[b] = 0;
                    m_pulse[b] = 0; m_run[b] = 0;
                end
                for (int i = 0; i < 16; i++) m_cell[i] = 0;
                m_r = 0; m_c = 0; m_k = 0; m_base = 0; m_n = 0;
            end else begin
                if (m_pulse[4]) m_cell[m_idx()] = (m_cell[m_idx()] + 1) % 8;
                vert = int'(m_pulse[1]) - int'(m_pulse[0]);
                horz = int'(m_pulse[3]) - int'(m_pulse[2]);
                m_r = (m_r + vert + 4) % 4;
                m_c = (m_c + horz + 4) % 4;
                if (m_pulse[0] || m_pulse[1] || m_pulse[2] || m_pulse[3] || m_pulse[4]) begin
                    m_k = 0; m_base = 1;
                end else begin
                    m_k++;
                end
                for (int b = 0; b < 5; b++) begin
                    nxt_pulse[b] = 0;
                    if (m_s2[b] != m_state[b]) begin
                        m_run[b]++;
                        if (m_run[b] == DEB) begin
                            m_state[b] = m_s2[b];
                            m_run[b]   = 0;
                            nxt_pulse[b] = m_s2[b] && m_armed[b];
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                    if (m_n >= 2 && !m_s2[b]) m_armed[b] = 1;
                    m_s2[b] = m_s1[b];
                    m_s1[b] = raw[b];
                end
                m_pulse = nxt_pulse;
                m_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_color, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic press(input logic [4:0] m, input int hold, input int gap);
        set_btns(m);
        step(hold);
        set_btns(5'b0);
        step(gap);
    endtask

    task automatic wait_phase_low();
        int t;
        t = 0;
        while (m_phase() && t < 20) begin
            step(1);
            t++;
        end
        if (m_phase()) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_phase_low: blink phase still 1 after %0d cycles", t);
        end
    endtask

    task automatic check_reset_image(input string name);
        for (int p = 15; p >= 0; p--) begin
            posicion = 4'(p);
            #1;
            check({name, "_idx"}, cursor_idx, 15);
            check({name, "_color"}, dirColor, 0);
            step(1);
        end
    endtask

    initial begin
        int c7, c2, segs;
        // 1: reset held three cycles
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        #1;
        check("rst_phase", blink_phase, 0);
        check_reset_image("s1");

        // 2: short glitch is ignored, long press steps colour once
        press(5'b10000, 2, 10);
        posicion = 4'd15;
        wait_phase_low();
        #1;
        check("glitch_color", dirColor, 0);
        press(5'b10000, 10, 10);
        wait_phase_low();
        #1;
        check("one_step_color", dirColor, 1);
        for (int i = 0; i < 7; i++) press(5'b10000, 10, 8);
        wait_phase_low();
        #1;
        check("eight_step_wrap", dirColor, 0);

        // 3: wrap-around moves
        press(5'b00001, 8, 6);
        check("up_wrap", cursor_idx, 12);
        press(5'b00100, 8, 6);
        check("left_wrap", cursor_idx, 0);
        press(5'b01000, 8, 6);
        check("right_wrap", cursor_idx, 12);
        press(5'b00010, 8, 6);
        check("down_wrap", cursor_idx, 15);

        // 4: up+down cancel, right applies, colour uses the pre-move cursor
        press(5'b11011, 8, 6);
        check("simul_idx", cursor_idx, 11);
        posicion = 4'd15;
        #1;
        check("simul_color", dirColor, 1);

        // 5: blink on cell 15 holding colour 2
        press(5'b00100, 8, 6);
        press(5'b10000, 10, 10);
        c7 = 0;
        c2 = 0;
        for (int i = 0; i < 16; i++) begin
            if (dirColor == 3'd7) c7++;
            if (dirColor == 3'd2) c2++;
            step(1);
        end
        check("blink_on_cycles", c7, 8);
        check("blink_off_cycles", c2, 8);

        // 6: reset mid-debounce and mid-blink with a button held through release
        set_btns(5'b00001);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("rst2_phase", blink_phase, 0);
        check_reset_image("s6");
        step(6);
        set_btns(5'b0);
        step(10);
        check("held_no_pulse", cursor_idx, 15);
        press(5'b00001, 8, 6);
        check("repress_pulse", cursor_idx, 12);

        // Random traffic, checked every cycle by the model
        segs = 0;
        while (segs < 300) begin
            set_btns(5'($urandom_range(0, 31) & $urandom_range(0, 31)));
            repeat ($urandom_range(1, 12)) begin
                posicion = 4'($urandom_range(0, 15));
                rst = ($urandom_range(0, 199) == 0);
                step(1);
            end
            rst = 1'b0;
            segs++;
        end
        set_btns(5'b0);
        step(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
